fc8_palette_out: RTL and testbench

//  Final video stage downstream of fc8_graphics: maps the 8-bit colour index stream to 12-bit RGB444 via a 256-entry palette RAM.
//  Re-aligns hsync/vsync to the pipelined pixel data and forces black during blanking.

---
 rtl/fc8_video_pkg.sv | 23 ++
 rtl/fc8_pal_wr_fifo.sv | 57 +++++
 rtl/fc8_palette_out.sv | 148 ++++++++++++++
 tb/tb_fc8_palette_out.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc8_video_pkg.sv
// Shared definitions for the fc8 video output path.
//   RGB_W         : packed RGB444 width
//   PAL_WR_W      : width of one queued palette write {addr, rgb}
//   pal_state_e   : palette controller state (INIT loads defaults, RUN serves CPU writes)
//   idx_to_rgb444 : default palette expansion of an RRRGGGBB index
package fc8_video_pkg;

    localparam int CB_DEF   = 4;
    localparam int RGB_W    = 3 * CB_DEF;
    localparam int PAL_WR_W = 8 + RGB_W;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } pal_state_e;

    // 3-bit channels replicate their MSB into the LSB, the 2-bit blue channel
    // is doubled, so full-scale indices map to full-scale colour.
    function automatic logic [RGB_W-1:0] idx_to_rgb444(input logic [7:0] idx);
        return {idx[7:5], idx[7], idx[4:2], idx[4], idx[1:0], idx[1:0]};
    endfunction

endpackage

// File: rtl/fc8_pal_wr_fifo.sv
// Synchronous FIFO for pending palette writes.
//   clk, rst         : clock, synchronous active-high reset (flushes contents)
//   push, push_data  : enqueue; ignored while full
//   pop              : dequeue; ignored while empty
//   head             : oldest entry (valid while !empty)
//   full, empty      : status
//   count            : occupancy 0..DEPTH
module fc8_pal_wr_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 20,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fc8_palette_out.sv
// Final video stage: colour index -> RGB444 through a 256-entry palette RAM.
//   pixel_clk, rst        : clock, synchronous active-high reset
//   pix_index_in          : colour index from the graphics stage
//   blank_in/hsync_in/vsync_in : timing aligned with pix_index_in (syncs active-low)
//   pal_wr_valid_in/ready_out, pal_wr_addr_in, pal_wr_data_in : CPU palette write port
//   pal_pending_out       : queued write count
//   init_done_out         : default palette loaded
//   vga_*_out             : colour and syncs, 2 cycles after the inputs
module fc8_palette_out
    import fc8_video_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int DEFER_WRITES = 1,
    parameter int CB           = 4
) (
    input  logic            pixel_clk,
    input  logic            rst,
    input  logic [7:0]      pix_index_in,
    input  logic            blank_in,
    input  logic            hsync_in,
    input  logic            vsync_in,
    input  logic            pal_wr_valid_in,
    output logic            pal_wr_ready_out,
    input  logic [7:0]      pal_wr_addr_in,
    input  logic [3*CB-1:0] pal_wr_data_in,
    output logic [2:0]      pal_pending_out,
    output logic            init_done_out,
    output logic [CB-1:0]   vga_r_out,
    output logic [CB-1:0]   vga_g_out,
    output logic [CB-1:0]   vga_b_out,
    output logic            vga_hsync_out,
    output logic            vga_vsync_out
);

    localparam int PIX_W = 3 * CB;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    pal_state_e          state;
    pal_state_e          state_nxt;
    logic [7:0]          init_cnt;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [8+PIX_W-1:0]  fifo_head;
    logic [CW-1:0]       fifo_count;

    logic                ram_we;
    logic [7:0]          ram_waddr;
    logic [PIX_W-1:0]    ram_wdata;
    logic [PIX_W-1:0]    pal_ram [256];

    logic [PIX_W-1:0]    s1_rgb;
    logic                s1_black;
    logic                s1_hs;
    logic                s1_vs;
    logic [PIX_W-1:0]    s2_rgb;

    // ---------------- controller ----------------
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) init_cnt <= init_cnt + 8'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (init_cnt == 8'hFF) state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
    end

    assign init_done_out    = (state == ST_RUN);
    assign pal_wr_ready_out = (state == ST_RUN) && !fifo_full;
    assign fifo_push        = pal_wr_valid_in && pal_wr_ready_out;
    assign fifo_pop         = (state == ST_RUN) && !fifo_empty &&
                              ((DEFER_WRITES == 0) || blank_in);
    assign pal_pending_out  = 3'(fifo_count);

    fc8_pal_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8 + PIX_W)
    ) u_fifo (
        .clk       (pixel_clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({pal_wr_addr_in, pal_wr_data_in}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Single write port: default loader during INIT, FIFO drain during RUN.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = fifo_head[8+PIX_W-1 -: 8];
        ram_wdata = fifo_head[PIX_W-1:0];
        if (state == ST_INIT) begin
            ram_we    = 1'b1;
            ram_waddr = init_cnt;
            ram_wdata = PIX_W'(idx_to_rgb444(init_cnt));
        end else if (fifo_pop) begin
            ram_we    = 1'b1;
        end
    end

    // Read and write in one block: a same-cycle read of the written entry
    // returns the old colour.
    always_ff @(posedge pixel_clk) begin
        if (ram_we) pal_ram[ram_waddr] <= ram_wdata;
        s1_rgb <= pal_ram[pix_index_in];
    end

    // ---------------- pixel pipeline ----------------
    // The INIT flag travels with the pixel so the RAM read taken during the
    // last load cycle is still blanked.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            s1_black      <= 1'b1;
            s1_hs         <= 1'b1;
            s1_vs         <= 1'b1;
            s2_rgb        <= '0;
            vga_hsync_out <= 1'b1;
            vga_vsync_out <= 1'b1;
        end else begin
            s1_black      <= blank_in || (state == ST_INIT);
            s1_hs         <= hsync_in;
            s1_vs         <= vsync_in;
            s2_rgb        <= s1_black ? '0 : s1_rgb;
            vga_hsync_out <= s1_hs;
            vga_vsync_out <= s1_vs;
        end
    end

    assign vga_r_out = s2_rgb[3*CB-1 -: CB];
    assign vga_g_out = s2_rgb[2*CB-1 -: CB];
    assign vga_b_out = s2_rgb[CB-1:0];

endmodule

// File: tb/tb_fc8_palette_out.sv
module tb_fc8_palette_out;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, blank, hs, vs, valid;
    logic [7:0]  idx, waddr;
    logic [11:0] wdata;

    logic        ready, done, ohs, ovs;
    logic [2:0]  pending;
    logic [3:0]  r, g, b;

    logic        ready_nd, done_nd, ohs_nd, ovs_nd;
    logic [2:0]  pending_nd;
    logic [3:0]  r_nd, g_nd, b_nd;

    int checks = 0;
    int errors = 0;

    fc8_palette_out #(.FIFO_DEPTH(DEPTH), .DEFER_WRITES(1), .CB(4)) dut (
        .pixel_clk(clk), .rst(rst), .pix_index_in(idx), .blank_in(blank),
        .hsync_in(hs), .vsync_in(vs), .pal_wr_valid_in(valid),
        .pal_wr_ready_out(ready), .pal_wr_addr_in(waddr), .pal_wr_data_in(wdata),
        .pal_pending_out(pending), .init_done_out(done),
        .vga_r_out(r), .vga_g_out(g), .vga_b_out(b),
        .vga_hsync_out(ohs), .vga_vsync_out(ovs)
    );

    // Immediate-drain variant, used to observe read-before-write on visible pixels.
    fc8_palette_out #(.FIFO_DEPTH(DEPTH), .DEFER_WRITES(0), .CB(4)) dut_nd (
        .pixel_clk(clk), .rst(rst), .pix_index_in(idx), .blank_in(blank),
        .hsync_in(hs), .vsync_in(vs), .pal_wr_valid_in(valid),
        .pal_wr_ready_out(ready_nd), .pal_wr_addr_in(waddr), .pal_wr_data_in(wdata),
        .pal_pending_out(pending_nd), .init_done_out(done_nd),
        .vga_r_out(r_nd), .vga_g_out(g_nd), .vga_b_out(b_nd),
        .vga_hsync_out(ohs_nd), .vga_vsync_out(ovs_nd)
    );

    // ---------------- reference model (deferred instance) ----------------
    logic [11:0] pal_m [256];
    logic [19:0] q_m [$];
    bit          m_done;
    int          m_cnt;
    logic [11:0] st_rgb, e_rgb;
    logic        st_hs, st_vs, e_hs, e_vs;

    function automatic logic [11:0] dflt(input int i);
        int rr, gg, bb;
        rr = i / 32;
        gg = (i / 4) % 8;
        bb = i % 4;
        return 12'(((rr * 2 + rr / 4) * 256) + ((gg * 2 + gg / 4) * 16) + bb * 5);
    endfunction

    function automatic logic [18:0] expv();
        return {e_rgb, e_hs, e_vs, m_done && (q_m.size() < DEPTH),
                3'(q_m.size()), m_done};
    endfunction

    function automatic logic [18:0] actv();
        return {r, g, b, ohs, ovs, ready, pending, done};
    endfunction

    // Advance the model by one clock with the inputs currently applied, then
    // let the DUT take the same edge; outputs are read on the falling edge.
    task automatic tick();
        bit          rdy;
        logic [19:0] e;
        if (rst) begin
            q_m.delete();
            m_cnt  = 0;
            m_done = 0;
            e_rgb  = '0; e_hs = 1'b1; e_vs = 1'b1;
            st_rgb = '0; st_hs = 1'b1; st_vs = 1'b1;
        end else begin
            e_rgb  = st_rgb; e_hs = st_hs; e_vs = st_vs;
            st_rgb = (blank || !m_done) ? 12'h000 : pal_m[idx];
            st_hs  = hs;
            st_vs  = vs;
            rdy    = m_done && (q_m.size() < DEPTH);
            if (!m_done) begin
                pal_m[m_cnt] = dflt(m_cnt);
                if (m_cnt == 255) m_done = 1;
                m_cnt++;
            end else if (blank && q_m.size() > 0) begin
                e = q_m.pop_front();
                pal_m[e[19:12]] = e[11:0];
            end
            if (valid && rdy) q_m.push_back({waddr, wdata});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1; valid = 0; blank = 0; hs = 1; vs = 1; idx = 8'h00;
        waddr = 8'h00; wdata = 12'h000;
        tick(); tick();
        checks++;
        if (actv() !== {12'h000, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0}) begin
            errors++; $display("FAIL reset_state: got %h expected %h", actv(),
                               {12'h000, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0});
        end
        checks++;
        if ({r_nd, g_nd, b_nd, ready_nd, pending_nd, done_nd} !== 17'h0) begin
            errors++; $display("FAIL reset_state_nd: got %h expected 0",
                               {r_nd, g_nd, b_nd, ready_nd, pending_nd, done_nd});
        end
    endtask

    task automatic test_init();
        int done_at = 0;
        int rdy_hi  = 0;
        rst = 0; idx = 8'hE0; blank = 0;
        for (int i = 1; i <= 300 && done_at == 0; i++) begin
            tick();
            checks++;
            if (actv() !== expv()) begin
                errors++; $display("FAIL init_cycle%0d: got %h expected %h", i, actv(), expv());
            end
            if (!done && ready) rdy_hi++;
            if (done) done_at = i;
        end
        checks++;
        if (done_at != 256) begin
            errors++; $display("FAIL init_length: got %0d expected 256", done_at);
        end
        checks++;
        if (rdy_hi != 0) begin
            errors++; $display("FAIL init_ready: got %0d ready cycles expected 0", rdy_hi);
        end
        tick(); tick();
        checks++;
        if ({r, g, b} !== 12'hF00) begin
            errors++; $display("FAIL pix_E0: got %h expected F00", {r, g, b});
        end
        idx = 8'h03;
        tick(); tick();
        checks++;
        if ({r, g, b} !== 12'h00F) begin
            errors++; $display("FAIL pix_03: got %h expected 00F", {r, g, b});
        end
    endtask

    task automatic test_sync();
        logic hs_drv [45];
        logic vs_drv [45];
        int   hlow = 0, vlow = 0;
        blank = 0;
        for (int i = 0; i < 45; i++) begin
            hs = !(i >= 5 && i < 29);
            vs = !(i >= 10 && i < 12);
            hs_drv[i] = hs; vs_drv[i] = vs;
            idx = 8'($urandom);
            tick();
            checks++;
            if (actv() !== expv()) begin
                errors++; $display("FAIL sync_cycle%0d: got %h expected %h", i, actv(), expv());
            end
            if (i >= 1) begin
                checks++;
                if ({ohs, ovs} !== {hs_drv[i-1], vs_drv[i-1]}) begin
                    errors++; $display("FAIL sync_delay%0d: got %b%b expected %b%b", i,
                                       ohs, ovs, hs_drv[i-1], vs_drv[i-1]);
                end
            end
            if (!ohs) hlow++;
            if (!ovs) vlow++;
        end
        checks++;
        if (hlow != 24 || vlow != 2) begin
            errors++; $display("FAIL sync_width: got %0d/%0d expected 24/2", hlow, vlow);
        end
        hs = 1; vs = 1;
    endtask

    task automatic test_blank();
        blank = 1; idx = 8'hFF;
        tick(); tick();
        checks++;
        if ({r, g, b} !== 12'h000) begin
            errors++; $display("FAIL blank_black: got %h expected 000", {r, g, b});
        end
        blank = 0;
        tick(); tick();
        checks++;
        if ({r, g, b} !== 12'hFFF) begin
            errors++; $display("FAIL pix_FF: got %h expected FFF", {r, g, b});
        end
    endtask

    task automatic test_defer();
        blank = 0; idx = 8'h10; valid = 1; waddr = 8'h10; wdata = 12'hABC;
        tick();
        valid = 0;
        checks++;
        if (pending !== 3'd1) begin
            errors++; $display("FAIL defer_pending: got %0d expected 1", pending);
        end
        tick(); tick();
        checks++;
        if ({r, g, b} !== dflt(8'h10)) begin
            errors++; $display("FAIL defer_old: got %h expected %h", {r, g, b}, dflt(8'h10));
        end
        blank = 1;
        tick();
        checks++;
        if (pending !== 3'd0) begin
            errors++; $display("FAIL defer_drain: got %0d expected 0", pending);
        end
        blank = 0;
        tick(); tick();
        checks++;
        if ({r, g, b} !== 12'hABC) begin
            errors++; $display("FAIL defer_new: got %h expected ABC", {r, g, b});
        end
    endtask

    task automatic test_fifo_full();
        logic [11:0] d [4];
        blank = 0; idx = 8'h00;
        for (int i = 0; i < 4; i++) begin
            valid = 1; waddr = 8'(8'h40 + i); d[i] = 12'($urandom); wdata = d[i];
            tick();
            checks++;
            if (actv() !== expv()) begin
                errors++; $display("FAIL full_fill%0d: got %h expected %h", i, actv(), expv());
            end
        end
        checks++;
        if ({ready, pending} !== {1'b0, 3'd4}) begin
            errors++; $display("FAIL full_state: got %b/%0d expected 0/4", ready, pending);
        end
        waddr = 8'h50; wdata = 12'h123;
        tick();
        valid = 0;
        checks++;
        if (pending !== 3'd4) begin
            errors++; $display("FAIL full_ignore: got %0d expected 4", pending);
        end
        blank = 1;
        for (int k = 3; k >= 0; k--) begin
            tick();
            checks++;
            if (pending !== 3'(k)) begin
                errors++; $display("FAIL full_drain: got %0d expected %0d", pending, k);
            end
        end
        blank = 0; idx = 8'h43;
        tick(); tick();
        checks++;
        if ({r, g, b} !== d[3]) begin
            errors++; $display("FAIL full_data: got %h expected %h", {r, g, b}, d[3]);
        end
        idx = 8'h50;
        tick(); tick();
        checks++;
        if ({r, g, b} !== dflt(8'h50)) begin
            errors++; $display("FAIL full_lost5th: got %h expected %h", {r, g, b}, dflt(8'h50));
        end
    endtask

    task automatic test_rbw();
        blank = 0; idx = 8'h00; valid = 1; waddr = 8'h20; wdata = 12'h5A5;
        tick();
        valid = 0; idx = 8'h20;
        checks++;
        if (pending_nd !== 3'd1) begin
            errors++; $display("FAIL rbw_push: got %0d expected 1", pending_nd);
        end
        tick();
        checks++;
        if (pending_nd !== 3'd0) begin
            errors++; $display("FAIL rbw_pop: got %0d expected 0", pending_nd);
        end
        tick();
        checks++;
        if ({r_nd, g_nd, b_nd} !== dflt(8'h20)) begin
            errors++; $display("FAIL rbw_old: got %h expected %h", {r_nd, g_nd, b_nd}, dflt(8'h20));
        end
        tick();
        checks++;
        if ({r_nd, g_nd, b_nd} !== 12'h5A5) begin
            errors++; $display("FAIL rbw_new: got %h expected 5A5", {r_nd, g_nd, b_nd});
        end
        checks++;
        if (actv() !== expv()) begin
            errors++; $display("FAIL rbw_main: got %h expected %h", actv(), expv());
        end
        blank = 1;
        tick();
        blank = 0;
        tick(); tick();
        checks++;
        if ({r, g, b} !== 12'h5A5) begin
            errors++; $display("FAIL rbw_main_new: got %h expected 5A5", {r, g, b});
        end
    endtask

    task automatic test_mid_reset();
        int done_at = 0;
        rst = 1; blank = 0; valid = 0;
        tick();
        rst = 0;
        repeat (100) tick();
        rst = 1;
        tick();
        rst = 0;
        checks++;
        if (actv() !== expv()) begin
            errors++; $display("FAIL rst_init_state: got %h expected %h", actv(), expv());
        end
        for (int i = 1; i <= 300 && done_at == 0; i++) begin
            tick();
            if (done) done_at = i;
        end
        checks++;
        if (done_at != 256) begin
            errors++; $display("FAIL rst_init_length: got %0d expected 256", done_at);
        end
        valid = 1; waddr = 8'h60; wdata = 12'h0F0;
        tick();
        waddr = 8'h61; wdata = 12'h0F1;
        tick();
        valid = 0;
        checks++;
        if (pending !== 3'd2) begin
            errors++; $display("FAIL rst_pending2: got %0d expected 2", pending);
        end
        rst = 1;
        tick();
        rst = 0;
        checks++;
        if ({pending, ready, done} !== 5'b000_0_0) begin
            errors++; $display("FAIL rst_flush: got %b expected 00000", {pending, ready, done});
        end
        repeat (256) tick();
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL rst_redone: got %b expected 1", done);
        end
        blank = 1;
        tick();
        blank = 0; idx = 8'h60;
        tick(); tick();
        checks++;
        if ({r, g, b} !== dflt(8'h60)) begin
            errors++; $display("FAIL rst_lost_write: got %h expected %h", {r, g, b}, dflt(8'h60));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2500; i++) begin
            rst   = ($urandom_range(0, 799) == 0);
            blank = ($urandom_range(0, 2) == 0);
            valid = $urandom_range(0, 1);
            waddr = 8'($urandom_range(0, 15));
            wdata = 12'($urandom);
            idx   = 8'($urandom_range(0, 15));
            hs    = $urandom_range(0, 1);
            vs    = $urandom_range(0, 1);
            tick();
            checks++;
            if (actv() !== expv()) begin
                errors++; $display("FAIL random_cycle%0d: got %h expected %h", i, actv(), expv());
            end
        end
        rst = 0; valid = 0;
    endtask

    initial begin
        test_reset();
        test_init();
        test_sync();
        test_blank();
        test_defer();
        test_fifo_full();
        test_rbw();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
